seq_pattern_tx: RTL



---
 rtl/seq_pattern_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first for a
// programmable number of repetitions, with an optional idle gap between repetitions.
module seq_pattern_tx #(
  parameter int                WIDTH           = 4,
  parameter logic [WIDTH-1:0]  PATTERN_DEFAULT = 4'b1010,
  parameter int                REP_W           = 8,
  parameter int                GAP_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_default,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start, outputs quiet
  // SEND  | outputs currently show pat_q[idx]
  // GAP   | idle spacing between repetitions, gap_cnt cycles remaining incl. current
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  localparam int            IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] pat_q;
  logic [IW-1:0]    idx;
  logic [REP_W-1:0] reps_left;
  logic [GAP_W-1:0] gap_len;
  logic [GAP_W-1:0] gap_cnt;
  logic [WIDTH-1:0] pat_sel;

  assign pat_sel = use_default ? PATTERN_DEFAULT : pattern;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pat_q       <= '0;
      idx         <= '0;
      reps_left   <= '0;
      gap_len     <= '0;
      gap_cnt     <= '0;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          out         <= 1'b0;
          out_valid   <= 1'b0;
          frame_start <= 1'b0;
          busy        <= 1'b0;
          if (start) begin
            pat_q     <= pat_sel;
            reps_left <= reps;
            gap_len   <= gap;
            idx       <= IDX_TOP;
            if (reps == '0) begin
              done <= 1'b1;
            end else begin
              state       <= SEND;
              out         <= pat_sel[WIDTH-1];
              out_valid   <= 1'b1;
              frame_start <= 1'b1;
              busy        <= 1'b1;
            end
          end
        end
        SEND: begin
          if (abort) begin
            state       <= IDLE;
            out         <= 1'b0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
          end else if (idx != '0) begin
            idx         <= idx - IW'(1);
            out         <= pat_q[idx - IW'(1)];
            frame_start <= 1'b0;
          end else if (reps_left == REP_W'(1)) begin
            state       <= IDLE;
            reps_left   <= '0;
            out         <= 1'b0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else begin
            reps_left <= reps_left - REP_W'(1);
            if (gap_len != '0) begin
              state       <= GAP;
              gap_cnt     <= gap_len;
              out         <= 1'b0;
              out_valid   <= 1'b0;
              frame_start <= 1'b0;
            end else begin
              idx         <= IDX_TOP;
              out         <= pat_q[WIDTH-1];
              frame_start <= 1'b1;
            end
          end
        end
        GAP: begin
          if (abort) begin
            state   <= IDLE;
            gap_cnt <= '0;
            busy    <= 1'b0;
          end else if (gap_cnt == GAP_W'(1)) begin
            state       <= SEND;
            gap_cnt     <= '0;
            idx         <= IDX_TOP;
            out         <= pat_q[WIDTH-1];
            out_valid   <= 1'b1;
            frame_start <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state       <= IDLE;
          out         <= 1'b0;
          out_valid   <= 1'b0;
          frame_start <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
